// File: rtl/posit_round_pipe_pkg.sv
// Shared types and constants for the posit processing unit (PPU) rounding path.
// No ports. Exports:
//   PPU_N / PPU_ES  posit width and exponent field width
//   posit_body_t    magnitude body, sign excluded (N-1 bits)
//   posit_word_t    full signed posit word (N bits)
//   NAR_WORD, MAXPOS_BODY, MINPOS_BODY  special encodings
//   round_flags_t   round/sticky/special flags that accompany a body
package ppu_pkg;

  localparam int PPU_N  = 16;
  localparam int PPU_ES = 1;

  typedef logic [PPU_N-2:0] posit_body_t;
  typedef logic [PPU_N-1:0] posit_word_t;

  localparam posit_word_t NAR_WORD    = {1'b1, {(PPU_N-1){1'b0}}};
  localparam posit_body_t MAXPOS_BODY = '1;
  localparam posit_body_t MINPOS_BODY = posit_body_t'(1);

  typedef struct packed {
    logic round;
    logic sticky;
    logic is_zero;
    logic is_nar;
  } round_flags_t;

endpackage

// File: rtl/posit_round_pipe_if.sv
// Valid/ready stream bundle for the posit rounding pipe.
// Upstream side : in_valid, in_ready, body_in, sign_in, round_bit, sticky_bit,
//                 is_zero, is_nar
// Downstream side: out_valid, out_ready, posit_out
// Modports: slave = the pipe itself, master = the block driving and draining it.
interface posit_round_pipe_if;
  import ppu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  posit_body_t body_in;
  logic        sign_in;
  logic        round_bit;
  logic        sticky_bit;
  logic        is_zero;
  logic        is_nar;
  logic        out_valid;
  logic        out_ready;
  posit_word_t posit_out;

  modport slave (
    input  in_valid, body_in, sign_in, round_bit, sticky_bit, is_zero, is_nar,
    input  out_ready,
    output in_ready, out_valid, posit_out
  );

  modport master (
    output in_valid, body_in, sign_in, round_bit, sticky_bit, is_zero, is_nar,
    output out_ready,
    input  in_ready, out_valid, posit_out
  );

endinterface

// File: rtl/posit_round_pipe_rne.sv
// Combinational round-to-nearest-even on a posit magnitude body.
// Ports:
//   body       in   truncated magnitude (regime|exp|frac)
//   round_bit  in   first discarded bit
//   sticky_bit in   OR of remaining discarded bits
//   is_zero    in   exact-zero result flag
//   mag        out  rounded magnitude, saturating at maxpos and floored at minpos
module round_nearest_even
  import ppu_pkg::*;
(
  input  posit_body_t body,
  input  logic        round_bit,
  input  logic        sticky_bit,
  input  logic        is_zero,
  output posit_body_t mag
);

  logic inc;

  always_comb begin
    inc = round_bit & (body[0] | sticky_bit);
    // Incrementing maxpos would carry into the NaR pattern.
    if (body == MAXPOS_BODY) inc = 1'b0;
    // A nonzero value whose body truncated to zero must not round to zero.
    if ((body == '0) && !is_zero) mag = MINPOS_BODY;
    else                          mag = body + posit_body_t'(inc);
  end

endmodule

// File: rtl/posit_round_pipe.sv
// Final rounding/packing stage of the posit encoder.
// Two-stage valid/ready pipeline: S1 rounds the magnitude, S2 applies the
// sign and the zero/NaR overrides and drives the result word.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset, drops all in-flight beats
//   bus  slave modport of posit_round_pipe_if (input beat, output beat)
module posit_round_pipe
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  posit_round_pipe_if.slave  bus
);

  function automatic posit_word_t pack_word(input posit_body_t mag,
                                            input logic        sign,
                                            input logic        zero,
                                            input logic        nar);
    posit_word_t w;
    w = {1'b0, mag};
    if (sign) w = -w;
    if (nar)       w = NAR_WORD;
    else if (zero) w = '0;
    return w;
  endfunction

  round_flags_t in_flags;
  posit_body_t  rne_mag;

  logic         s1_v_q, s1_v_d;
  posit_body_t  s1_mag_q, s1_mag_d;
  logic         s1_sign_q, s1_sign_d;
  logic         s1_zero_q, s1_zero_d;
  logic         s1_nar_q, s1_nar_d;

  logic         s2_v_q, s2_v_d;
  posit_word_t  s2_word_q, s2_word_d;

  logic         s1_adv, s2_adv;

  assign in_flags = '{round:   bus.round_bit,
                      sticky:  bus.sticky_bit,
                      is_zero: bus.is_zero,
                      is_nar:  bus.is_nar};

  round_nearest_even u_rne (
    .body       (bus.body_in),
    .round_bit  (in_flags.round),
    .sticky_bit (in_flags.sticky),
    .is_zero    (in_flags.is_zero),
    .mag        (rne_mag)
  );

  assign s2_adv       = !s2_v_q || bus.out_ready;
  assign s1_adv       = !s1_v_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // S1: register the rounded magnitude with its sign and special flags
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_mag_d  = s1_mag_q;
    s1_sign_d = s1_sign_q;
    s1_zero_d = s1_zero_q;
    s1_nar_d  = s1_nar_q;
    if (s1_adv) begin
      s1_v_d    = bus.in_valid;
      s1_mag_d  = rne_mag;
      s1_sign_d = bus.sign_in;
      s1_zero_d = in_flags.is_zero;
      s1_nar_d  = in_flags.is_nar;
    end
  end

  // S2: signed, special-resolved result word
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_word_d = s2_word_q;
    if (s2_adv) begin
      s2_v_d    = s1_v_q;
      s2_word_d = pack_word(s1_mag_q, s1_sign_q, s1_zero_q, s1_nar_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_mag_q  <= '0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_nar_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_word_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mag_q  <= s1_mag_d;
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_nar_q  <= s1_nar_d;
      s2_v_q    <= s2_v_d;
      s2_word_q <= s2_word_d;
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.posit_out = s2_word_q;

endmodule
